// File: rtl/pcsp_mem_unit.sv
// rtl/pcsp_mem_unit.sv - PC/SP/memory-access engine with wait states and stack bounds checks
//
// Owns the program counter, stack pointer, instruction register and
// memory-value register, and sequences one single-port memory access per
// accepted request (FETCH, LOAD, STORE, PUSH, POP).
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_op                0 FETCH, 1 LOAD, 2 STORE, 3 PUSH, 4 POP, 5..7 no-op
//   req_addr, req_wdata   address for LOAD/STORE, data for STORE/PUSH
//   pc_load, pc_target    PC reload, honoured in every state
//   mem_en, mem_we        memory enable / write enable
//   mem_addr, mem_wdata   memory address / write data
//   mem_rdata             memory read data, sampled on the last access cycle
//   inst_out, memval_out  instruction register / loaded-popped value
//   pc_out, sp_out        current PC / SP
//   done                  one-cycle completion pulse
//   fault                 sticky stack overflow/underflow flag
module pcsp_mem_unit #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] PC_RESET = '0,
  parameter logic [WIDTH-1:0] SP_TOP   = 16'hFFFE,
  parameter logic [WIDTH-1:0] SP_LIMIT = 16'hF000,
  parameter int               MEM_WAIT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic             pc_load,
  input  logic [WIDTH-1:0] pc_target,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] inst_out,
  output logic [WIDTH-1:0] memval_out,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] sp_out,
  output logic             done,
  output logic             fault
);

  localparam logic [2:0] OP_FETCH = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_PUSH  = 3'd3;
  localparam logic [2:0] OP_POP   = 3'd4;

  localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);
  localparam logic [3:0]       WAIT_MAX = 4'(MEM_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       op_q;
  logic [3:0]       wait_cnt;
  logic [WIDTH-1:0] sp_dec, sp_inc;
  logic             accept, is_noop, push_ovf, pop_unf, short_op, last_beat;

  assign sp_dec    = sp_out - TWO;
  assign sp_inc    = sp_out + TWO;
  assign accept    = req_valid && req_ready;
  assign is_noop   = (req_op > OP_POP);
  assign push_ovf  = (req_op == OP_PUSH) && (sp_dec < SP_LIMIT);
  assign pop_unf   = (req_op == OP_POP) && (sp_out == SP_TOP);
  // No-ops and stack faults skip the memory phase entirely.
  assign short_op  = is_noop || push_ovf || pop_unf;
  assign last_beat = (state == S_ACCESS) && (wait_cnt == WAIT_MAX);

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = short_op ? S_DONE : S_ACCESS;
      S_ACCESS: if (last_beat) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Decoded output: held low during the reset cycle itself.
  always_comb begin
    req_ready = (state == S_IDLE) && !reset;
  end

  // Registered datapath and outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q       <= OP_FETCH;
      wait_cnt   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      inst_out   <= '0;
      memval_out <= '0;
      pc_out     <= PC_RESET;
      sp_out     <= SP_TOP;
      done       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      done <= (state_nxt == S_DONE);

      if (accept && !short_op) begin
        op_q      <= req_op;
        wait_cnt  <= '0;
        mem_en    <= 1'b1;
        mem_we    <= (req_op == OP_STORE) || (req_op == OP_PUSH);
        mem_wdata <= req_wdata;
        case (req_op)
          OP_FETCH: mem_addr <= pc_out;
          OP_PUSH:  mem_addr <= sp_dec;
          OP_POP:   mem_addr <= sp_out;
          default:  mem_addr <= req_addr;
        endcase
      end

      if (accept && (push_ovf || pop_unf)) fault <= 1'b1;

      if (state == S_ACCESS) begin
        wait_cnt <= wait_cnt + 4'd1;
        if (last_beat) begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          case (op_q)
            OP_FETCH: inst_out <= mem_rdata;
            OP_LOAD:  memval_out <= mem_rdata;
            OP_PUSH:  sp_out <= sp_dec;
            OP_POP: begin
              memval_out <= mem_rdata;
              sp_out     <= sp_inc;
            end
            default: ;
          endcase
        end
      end

      // An explicit reload overrides the fetch increment on the same edge.
      if (pc_load)                             pc_out <= pc_target;
      else if (last_beat && op_q == OP_FETCH)  pc_out <= pc_out + TWO;
    end
  end

endmodule

// File: tb/tb_pcsp_mem_unit.sv
// tb/tb_pcsp_mem_unit.sv - self-checking bench for pcsp_mem_unit
module tb_pcsp_mem_unit;

  localparam int          MEM_WAIT = 1;
  localparam logic [15:0] SP_TOP   = 16'hFFFE;
  localparam logic [15:0] SP_LIMIT = 16'hF000;
  localparam logic [2:0]  FETCH = 3'd0, LOAD = 3'd1, STORE = 3'd2, PUSH = 3'd3, POP = 3'd4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_target = '0;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] inst_out, memval_out, pc_out, sp_out;
  logic        done, fault;

  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];

  logic [15:0] m_pc, m_sp, m_inst, m_memval;
  logic        m_fault;

  int n_checks = 0;
  int n_fail   = 0;

  pcsp_mem_unit #(
    .WIDTH(16), .PC_RESET(16'h0000), .SP_TOP(SP_TOP), .SP_LIMIT(SP_LIMIT), .MEM_WAIT(MEM_WAIT)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .pc_load(pc_load), .pc_target(pc_target),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .inst_out(inst_out), .memval_out(memval_out), .pc_out(pc_out), .sp_out(sp_out),
    .done(done), .fault(fault)
  );

  always #5 clock = ~clock;

  // External single-port memory: asynchronous read, write on enabled edges.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clock) if (mem_en && mem_we) mem[mem_addr] = mem_wdata;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_sp = SP_TOP; m_inst = '0; m_memval = '0; m_fault = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = 1'b0; pc_load = 1'b0;
    tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_pc", pc_out, 16'h0000);
    chk("rst_sp", sp_out, SP_TOP);
    chk("rst_inst", inst_out, 0);
    chk("rst_memval", memval_out, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mwdata", mem_wdata, 0);
    chk("rst_en_we", {mem_en, mem_we}, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    reset = 1'b0;
    #1;
    chk("rst_ready_after", req_ready, 1);
    model_reset();
  endtask

  // One request from acceptance to the idle cycle after done. Expected
  // behaviour comes from the model state; busy cycles carry a junk request
  // that must be ignored.
  task automatic do_op(input logic [2:0] op, input logic [15:0] addr, input logic [15:0] wdata,
                       input logic jmp, input logic [15:0] jmp_tgt);
    logic [15:0] ea;
    logic        flt, is_mem, we;
    flt    = (op == PUSH && (m_sp - 16'd2) < SP_LIMIT) || (op == POP && m_sp == SP_TOP);
    is_mem = (op <= POP) && !flt;
    we     = (op == STORE) || (op == PUSH);
    case (op)
      FETCH:   ea = m_pc;
      PUSH:    ea = m_sp - 16'd2;
      POP:     ea = m_sp;
      default: ea = addr;
    endcase
    chk("accept_ready", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    tick();
    req_op = 3'($urandom_range(0, 7));
    req_addr = 16'($urandom);
    if (!is_mem) begin
      if (flt) m_fault = 1'b1;
      chk("short_done", done, 1);
      chk("short_en", mem_en, 0);
      chk("short_fault", fault, m_fault);
      chk("short_sp", sp_out, m_sp);
      chk("short_pc", pc_out, m_pc);
      chk("short_ready", req_ready, 0);
      tick();
    end else begin
      for (int k = 0; k <= MEM_WAIT; k++) begin
        chk("acc_en", mem_en, 1);
        chk("acc_we", mem_we, we);
        chk("acc_addr", mem_addr, ea);
        if (we) chk("acc_wdata", mem_wdata, wdata);
        chk("acc_done", done, 0);
        chk("acc_ready", req_ready, 0);
        if (k == MEM_WAIT && jmp) begin pc_load = 1'b1; pc_target = jmp_tgt; end
        tick();
        pc_load = 1'b0;
      end
      if (we) ref_mem[ea] = wdata;
      case (op)
        FETCH: begin m_inst = ref_mem[ea]; m_pc = m_pc + 16'd2; end
        LOAD:  m_memval = ref_mem[ea];
        PUSH:  m_sp = m_sp - 16'd2;
        POP:   begin m_memval = ref_mem[ea]; m_sp = m_sp + 16'd2; end
        default: ;
      endcase
      if (jmp) m_pc = jmp_tgt;
      chk("fin_done", done, 1);
      chk("fin_en_we", {mem_en, mem_we}, 0);
      chk("fin_pc", pc_out, m_pc);
      chk("fin_sp", sp_out, m_sp);
      chk("fin_inst", inst_out, m_inst);
      chk("fin_memval", memval_out, m_memval);
      chk("fin_fault", fault, m_fault);
      if (we) chk("fin_mem", mem[ea], ref_mem[ea]);
      chk("fin_ready", req_ready, 0);
      tick();
    end
    req_valid = 1'b0;
    chk("post_done", done, 0);
    chk("post_ready", req_ready, 1);
  endtask

  initial begin
    logic [15:0] v, saved;
    for (int i = 0; i < 65536; i++) begin
      v = 16'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[0] = 16'h1234; ref_mem[0] = 16'h1234;

    // Reset and first fetch from address 0
    do_reset();
    do_op(FETCH, 16'h0, 16'h0, 1'b0, 16'h0);
    chk("fetch0_inst", inst_out, 16'h1234);
    chk("fetch0_pc", pc_out, 16'h0002);

    // Push then pop
    do_op(PUSH, 16'h0, 16'hABCD, 1'b0, 16'h0);
    chk("push_sp", sp_out, 16'hFFFC);
    chk("push_mem", mem[16'hFFFC], 16'hABCD);
    do_op(POP, 16'h0, 16'h0, 1'b0, 16'h0);
    chk("pop_memval", memval_out, 16'hABCD);
    chk("pop_sp", sp_out, 16'hFFFE);

    // Underflow straight after reset; fault stays sticky
    do_reset();
    do_op(POP, 16'h0, 16'h0, 1'b0, 16'h0);
    chk("unf_fault", fault, 1);
    chk("unf_sp", sp_out, 16'hFFFE);
    do_op(LOAD, 16'h0002, 16'h0, 1'b0, 16'h0);
    chk("unf_sticky", fault, 1);

    // pc_load on the completing edge of a fetch wins over the increment
    do_op(FETCH, 16'h0, 16'h0, 1'b1, 16'h0400);
    chk("jmp_pc", pc_out, 16'h0400);
    chk("jmp_inst", inst_out, ref_mem[0]);

    // pc_load in idle, then fetch wraps PC
    pc_load = 1'b1; pc_target = 16'hFFFE;
    tick();
    pc_load = 1'b0;
    m_pc = 16'hFFFE;
    chk("idle_pcload", pc_out, 16'hFFFE);
    do_op(FETCH, 16'h0, 16'h0, 1'b0, 16'h0);
    chk("wrap_pc", pc_out, 16'h0000);

    // Reset during the first access cycle of a store aborts it
    chk("abort_ready", req_ready, 1);
    req_valid = 1'b1; req_op = STORE; req_addr = 16'h0800; req_wdata = 16'h5A5A;
    tick();
    req_valid = 1'b0;
    chk("abort_c1_we", {mem_en, mem_we}, 2'b11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_c2_we", {mem_en, mem_we}, 0);
    chk("abort_c2_done", done, 0);
    saved = mem[16'h0800];
    model_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_idle", {done, mem_en, mem_we}, 0);
    end
    chk("abort_mem", mem[16'h0800], saved);
    chk("abort_pc", pc_out, 16'h0000);

    // Fill the stack to the limit, then overflow
    do_reset();
    for (int i = 0; i < 16'h07FF; i++) do_op(PUSH, 16'h0, 16'($urandom), 1'b0, 16'h0);
    chk("fill_sp", sp_out, 16'hF000);
    saved = mem[16'hEFFE];
    do_op(PUSH, 16'h0, 16'h7777, 1'b0, 16'h0);
    chk("ovf_fault", fault, 1);
    chk("ovf_sp", sp_out, 16'hF000);
    chk("ovf_nowrite", mem[16'hEFFE], saved);

    // Randomised operations against the model
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic [2:0]  op;
      logic [15:0] a, t;
      op = 3'($urandom_range(0, 7));
      a  = 16'h0100 + 16'($urandom_range(0, 127)) * 16'd2;
      t  = 16'($urandom_range(0, 32767)) * 16'd2;
      do_op(op, a, 16'($urandom), ($urandom_range(0, 9) == 0), t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pcsp_mem_unit.md
# pcsp_mem_unit

Parametrised PC/stack-pointer/memory-access engine for the datapath: it owns the program counter, the stack pointer, the instruction register and the memory-value register, and it sequences every access to a single-port external memory with a configurable number of wait states. The control unit issues one operation at a time over a valid/ready handshake (fetch, load, store, push, pop) and receives a one-cycle `done` pulse. Stack bounds are checked, and violations raise a sticky fault without touching memory.

## Interface
- `WIDTH`, 16: data, address, PC and SP width.
- `PC_RESET`, 0: PC value after reset.
- `SP_TOP`, 16'hFFFE: SP value after reset (empty stack).
- `SP_LIMIT`, 16'hF000: lowest legal SP value.
- `MEM_WAIT`, 1: extra wait cycles per access, range 0..15.

- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  operation request.
- `req_ready`  out  1  unit can accept a request.
- `req_op`  in  3  0 FETCH, 1 LOAD, 2 STORE, 3 PUSH, 4 POP; 5–7 are treated as no-op.
- `req_addr`  in  WIDTH  address for LOAD/STORE.
- `req_wdata`  in  WIDTH  data for STORE/PUSH.
- `pc_load`  in  1  load PC from `pc_target` this edge.
- `pc_target`  in  WIDTH  branch/jump target.
- `mem_en`, `mem_we`  out  1  memory enable / write enable.
- `mem_addr`, `mem_wdata`  out  WIDTH  memory address / write data.
- `mem_rdata`  in  WIDTH  memory read data, valid on the last access cycle.
- `inst_out`  out  WIDTH  instruction register.
- `memval_out`  out  WIDTH  loaded/popped value register.
- `pc_out`, `sp_out`  out  WIDTH  current PC / SP.
- `done`  out  1  one-cycle completion pulse.
- `fault`  out  1  sticky stack overflow/underflow flag.

## Operation
- States: IDLE, ACCESS, DONE. `req_ready` = 1 only in IDLE.
- IDLE: on `req_valid && req_ready`, latch the op, address and data, then go to ACCESS with wait counter = 0.
- Latched address per op:
  - FETCH: PC at acceptance.
  - LOAD/STORE: `req_addr`.
  - PUSH: SP−2.
  - POP: SP.
- No-op opcodes go straight to DONE. They have no memory or register side effects.
- Overflow check: a PUSH with SP−2 < `SP_LIMIT` (unsigned) goes straight to DONE, sets `fault`, and leaves SP unchanged.
- Underflow check: a POP with SP == `SP_TOP` goes straight to DONE, sets `fault`, and leaves SP unchanged.
- ACCESS: lasts `MEM_WAIT`+1 cycles.
  - `mem_en` = 1 throughout, with `mem_addr` and `mem_wdata` held from the latch.
  - `mem_we` = 1 throughout for STORE/PUSH.
- On the edge leaving the last ACCESS cycle:
  - FETCH: `inst_out` ← `mem_rdata`; PC ← PC+2.
  - LOAD/POP: `memval_out` ← `mem_rdata`.
  - POP: SP ← SP+2.
  - PUSH: SP ← SP−2.
- DONE: lasts 1 cycle with `done` = 1, then returns to IDLE.
- `pc_load` is honoured in any state. If it coincides with a fetch's PC increment, `pc_load` wins.
- A fetch in flight keeps its latched address even if the PC is reloaded.
- All arithmetic is modulo 2^WIDTH: PC 16'hFFFE + 2 = 16'h0000.
- `fault` clears only on reset.

## Timing
- Reset values:
  - State IDLE.
  - `pc_out` = `PC_RESET`, `sp_out` = `SP_TOP`.
  - `inst_out`, `memval_out`, `mem_addr`, `mem_wdata` = 0.
  - `mem_en`, `mem_we`, `done`, `fault` = 0.
  - `req_ready` = 0 during the reset cycle and 1 in the cycle after.
- Reset mid-operation aborts the access. `mem_en`/`mem_we` are low from the next cycle, and no register update or `done` occurs.
- All outputs are registered except `req_ready`, which is decoded from state.
- Latency: a request accepted in cycle 0 drives memory in cycles 1..`MEM_WAIT`+1, and `done` is high in cycle `MEM_WAIT`+2. The next accept is possible in cycle `MEM_WAIT`+3.
- A fault or no-op accepted in cycle 0 gives `done` in cycle 1.
- Updated PC/SP/`inst_out`/`memval_out` are visible in the same cycle `done` is high.
- Requests presented while `req_ready` = 0 are ignored; no queueing.

## Test plan
All scenarios use defaults (`WIDTH` 16, `MEM_WAIT` 1).

- Reset, then FETCH with mem[0000]=16'h1234 -> `mem_en` high in cycles 1–2 at address 0000; in cycle 3 `done`=1, `inst_out`=16'h1234, `pc_out`=16'h0002.
- PUSH 16'hABCD then POP -> write at 16'hFFFC, `sp_out`=16'hFFFC after the push; the pop reads 16'hFFFC, giving `memval_out`=16'hABCD and `sp_out`=16'hFFFE.
- POP right after reset -> `done` in cycle 1, `mem_en` never high, `fault`=1 and stays 1, `sp_out`=16'hFFFE.
- PUSH until SP=16'hF000, then one more PUSH -> `fault`=1, `sp_out` stays 16'hF000, no write.
- FETCH in flight with `pc_load`=1, `pc_target`=16'h0400 asserted on the completing edge -> fetch still reads the old PC; `pc_out`=16'h0400, not old PC+2.
- `pc_load` to 16'hFFFE then FETCH -> `pc_out` wraps to 16'h0000. Reset asserted in cycle 1 of a STORE -> `mem_we` low in cycle 2, no `done`, memory unchanged after that cycle.
